// File: rtl/easy_axi_slv_rd_pkg.sv
// easy_axi_slv_rd_pkg: shared AXI encodings and address helpers for the easy_axi responders.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package easy_axi_slv_rd_pkg;

  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  // Helper functions work at a fixed wide width; callers zero-extend and truncate.
  localparam int MAX_ADDR_W  = 64;
  localparam int MAX_LEN_W   = 16;

  localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [AXI_BURST_W-1:0] BURST_RSVD  = 2'b11;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  function automatic logic [7:0] size_to_bytes(input logic [AXI_SIZE_W-1:0] size);
    return 8'd1 << size;
  endfunction

  // Address of the beat following 'addr'. 'burst' must already be the effective
  // addressing mode (reserved / illegal WRAP requests are mapped to INCR by the caller).
  function automatic logic [MAX_ADDR_W-1:0] next_addr(
    input logic [MAX_ADDR_W-1:0]  addr,
    input logic [AXI_SIZE_W-1:0]  size,
    input logic [MAX_LEN_W-1:0]   len,
    input logic [AXI_BURST_W-1:0] burst
  );
    logic [MAX_ADDR_W-1:0] bytes;
    logic [MAX_ADDR_W-1:0] span;
    logic [MAX_ADDR_W-1:0] aligned;
    bytes   = MAX_ADDR_W'(size_to_bytes(size));
    aligned = addr & ~(bytes - 1);
    span    = (MAX_ADDR_W'(len) + 1) * bytes;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~(span - 1)) | ((addr + bytes) & (span - 1));
      default:     next_addr = aligned + bytes;
    endcase
  endfunction

endpackage

// File: rtl/easy_axi_slv_ar_fifo.sv
// easy_axi_slv_ar_fifo: generic synchronous FIFO holding accepted read requests.
// Latency: a write is visible at rd_data the cycle after it is written.
// Backpressure: writes while full and reads while empty are ignored; caller gates on full/empty.
//
// Ports: clk, rst (sync active-high), wr_en/wr_data, rd_en/rd_data (show-ahead head),
//        full, empty, count (0..DEPTH).
module easy_axi_slv_ar_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/easy_axi_slv_rd.sv
// easy_axi_slv_rd: AXI4 read responder; queues AR requests, returns address-as-data R bursts.
// Latency: AR handshake in cycle N with idle engine -> first rvalid in cycle N+2; no bubble between queued bursts.
// Backpressure: arready drops while the request queue is full; R outputs hold while rvalid && !rready.
//
// Ports: clk, rst (sync active-high); AR channel axi_slv_ar{valid,ready,id,addr,len,size,burst};
//        R channel axi_slv_r{valid,ready,id,data,resp,last}.
module easy_axi_slv_rd
  import easy_axi_slv_rd_pkg::*;
#(
  parameter int                ID_W       = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                LEN_W      = 8,
  parameter int                AR_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(32'h0001_0000)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   axi_slv_arvalid,
  output logic                   axi_slv_arready,
  input  logic [ID_W-1:0]        axi_slv_arid,
  input  logic [ADDR_W-1:0]      axi_slv_araddr,
  input  logic [LEN_W-1:0]       axi_slv_arlen,
  input  logic [AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                   axi_slv_rvalid,
  input  logic                   axi_slv_rready,
  output logic [ID_W-1:0]        axi_slv_rid,
  output logic [DATA_W-1:0]      axi_slv_rdata,
  output logic [AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                   axi_slv_rlast
);

  typedef struct packed {
    logic [ID_W-1:0]        id;
    logic [ADDR_W-1:0]      addr;
    logic [LEN_W-1:0]       len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } ar_req_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                   state, state_nxt;
  ar_req_t                  push_req, head;
  logic                     q_push, q_pop, q_full, q_empty;
  logic [$clog2(AR_DEPTH):0] q_count;
  logic                     load, advance, r_hs, last_beat;

  // Current burst registers
  logic [ID_W-1:0]          cur_id;
  logic [ADDR_W-1:0]        cur_addr;
  logic [LEN_W-1:0]         cur_len;
  logic [AXI_SIZE_W-1:0]    cur_size;
  logic [AXI_BURST_W-1:0]   cur_burst;
  logic                     cur_err;
  logic [LEN_W-1:0]         beat_cnt;

  // Decode of the queue head, used when it is loaded
  logic                     head_wrap_len_ok;
  logic                     head_err;
  logic [AXI_BURST_W-1:0]   head_eff_burst;

  assign axi_slv_arready = !rst && !q_full;
  assign q_push          = axi_slv_arvalid && axi_slv_arready;
  assign push_req        = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                             size: axi_slv_arsize, burst: axi_slv_arburst};

  easy_axi_slv_ar_fifo #(
    .WIDTH ($bits(ar_req_t)),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (q_push),
    .wr_data (push_req),
    .rd_en   (q_pop),
    .rd_data (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (q_count <= ($clog2(AR_DEPTH)+1)'(AR_DEPTH));
    end
  end

  always_comb begin
    head_wrap_len_ok = (head.len == LEN_W'(1)) || (head.len == LEN_W'(3)) ||
                       (head.len == LEN_W'(7)) || (head.len == LEN_W'(15));
    head_err = (int'(size_to_bytes(head.size)) > DATA_W/8) ||
               (head.burst == BURST_RSVD) ||
               (head.burst == BURST_WRAP && !head_wrap_len_ok) ||
               (head.addr >= ADDR_LIMIT);
    // Reserved and illegal-length WRAP bursts still stream, addressed as INCR.
    head_eff_burst = head.burst;
    if (head.burst == BURST_RSVD || (head.burst == BURST_WRAP && !head_wrap_len_ok)) begin
      head_eff_burst = BURST_INCR;
    end
  end

  assign r_hs      = axi_slv_rvalid && axi_slv_rready;
  assign last_beat = (beat_cnt == cur_len);

  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          load      = 1'b1;
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (r_hs) begin
          if (!last_beat) begin
            advance = 1'b1;
          end else if (!q_empty) begin
            // Chain straight into the next queued burst.
            q_pop = 1'b1;
            load  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_id    <= '0;
      cur_addr  <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= BURST_INCR;
      cur_err   <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cur_id    <= head.id;
        cur_addr  <= head.addr;
        cur_len   <= head.len;
        cur_size  <= head.size;
        cur_burst <= head_eff_burst;
        cur_err   <= head_err;
        beat_cnt  <= '0;
      end else if (advance) begin
        cur_addr <= ADDR_W'(next_addr(MAX_ADDR_W'(cur_addr), cur_size,
                                      MAX_LEN_W'(cur_len), cur_burst));
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // R outputs are forced to zero whenever no beat is presented (including during reset).
  assign axi_slv_rvalid = !rst && (state == S_BURST);
  assign axi_slv_rid    = axi_slv_rvalid ? cur_id : '0;
  assign axi_slv_rdata  = axi_slv_rvalid ? DATA_W'(cur_addr) : '0;
  assign axi_slv_rresp  = (axi_slv_rvalid && cur_err) ? RESP_SLVERR : RESP_OKAY;
  assign axi_slv_rlast  = axi_slv_rvalid && last_beat;

endmodule

// File: tb/tb_easy_axi_slv_rd.sv
// tb_easy_axi_slv_rd: randomized + directed bench for easy_axi_slv_rd against a beat-list reference model.
// Latency: n/a.
// Backpressure: exercises rready stalls and a full request queue.
module tb_easy_axi_slv_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  always #5 clk = ~clk;

  easy_axi_slv_rd dut (
    .clk             (clk),
    .rst             (rst),
    .axi_slv_arvalid (arvalid),
    .axi_slv_arready (arready),
    .axi_slv_arid    (arid),
    .axi_slv_araddr  (araddr),
    .axi_slv_arlen   (arlen),
    .axi_slv_arsize  (arsize),
    .axi_slv_arburst (arburst),
    .axi_slv_rvalid  (rvalid),
    .axi_slv_rready  (rready),
    .axi_slv_rid     (rid),
    .axi_slv_rdata   (rdata),
    .axi_slv_rresp   (rresp),
    .axi_slv_rlast   (rlast)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  logic  mon_en   = 1'b0;
  logic  rr_rand  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expand a request into its full list of expected beats.
  task automatic model_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] bytes, span, base, aligned, a;
    logic        wrap_ok, err;
    logic [1:0]  mode;
    beat_t       b;
    bytes   = 32'd1 << size;
    wrap_ok = (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    err     = (bytes > 32'd4) || (burst == 2'b11) || (burst == 2'b10 && !wrap_ok) ||
              (addr >= 32'h0001_0000);
    mode    = (burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) ? 2'b01 : burst;
    span    = (32'(len) + 32'd1) * bytes;
    base    = addr & ~(span - 32'd1);
    aligned = addr & ~(bytes - 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      case (mode)
        2'b00:   a = addr;
        2'b10:   a = base + ((addr - base + 32'(i) * bytes) % span);
        default: a = (i == 0) ? addr : aligned + 32'(i) * bytes;
      endcase
      b.id   = id;
      b.data = a;
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
  endtask

  // Monitor on the falling edge: sees exactly the values the next rising edge will act on.
  logic        stall_prev  = 1'b0;
  logic        bubble_chk  = 1'b0;
  logic [38:0] hold_snap;
  always @(negedge clk) begin
    beat_t e;
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_rvalid", 64'(rvalid), 64'd1);
        chk("hold_rfields", 64'({rid, rdata, rresp, rlast}), 64'(hold_snap));
      end
      if (bubble_chk) chk("no_bubble", 64'(rvalid), 64'd1);
      bubble_chk = 1'b0;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rid",   64'(rid),   64'(e.id));
          chk("rdata", 64'(rdata), 64'(e.data));
          chk("rresp", 64'(rresp), 64'(e.resp));
          chk("rlast", 64'(rlast), 64'(e.last));
          if (rlast && exp_q.size() != 0) bubble_chk = 1'b1;
        end
      end
      stall_prev = rvalid && !rready;
      hold_snap  = {rid, rdata, rresp, rlast};
      if (arvalid && arready) model_push(arid, araddr, arlen, arsize, arburst);
    end else begin
      stall_prev = 1'b0;
      bubble_chk = 1'b0;
    end
  end

  // Random rready while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) rready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int budget,
                         output int waited);
    logic fired;
    fired   = 1'b0;
    waited  = 0;
    arvalid = 1'b1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    while (!fired && waited < budget) begin
      fired = arready;
      step(1);
      waited++;
    end
    arvalid = 1'b0;
    if (!fired) chk("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rvalid) && n < budget) begin
      step(1);
      n++;
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !rvalid), 64'd1);
  endtask

  initial begin
    int w;
    rst = 1'b1; arvalid = 1'b0; rready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    step(3);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rfields", 64'({rid, rdata, rresp, rlast}), 64'd0);
    rst = 1'b0;
    step(1);
    chk("post_rst_arready", 64'(arready), 64'd1);
    mon_en = 1'b1;

    // Single beat, first-beat latency.
    rready = 1'b1;
    send_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 4, w);
    chk("lat_cycle_n1", 64'(rvalid), 64'd0);
    step(1);
    chk("lat_cycle_n2", 64'(rvalid), 64'd1);
    wait_idle(20);

    // INCR then WRAP.
    send_ar(4'd1, 32'h104, 8'd3, 3'd2, 2'b01, 4, w);
    send_ar(4'd2, 32'h38,  8'd3, 3'd2, 2'b10, 4, w);
    wait_idle(40);

    // FIXED with a 5-cycle stall on the first beat.
    rready = 1'b0;
    send_ar(4'd5, 32'h20, 8'd2, 3'd2, 2'b00, 4, w);
    step(6);
    chk("stall_rvalid", 64'(rvalid), 64'd1);
    rready = 1'b1;
    wait_idle(20);

    // Fill the queue with rready low: one request in the engine plus AR_DEPTH queued.
    rready = 1'b0;
    for (int k = 0; k < 5; k++) send_ar(4'(k + 6), 32'h200 + 32'(k) * 32'h10, 8'd1, 3'd2, 2'b01, 1, w);
    arvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ar_full", 64'(arready), 64'd0);
      step(1);
    end
    rready = 1'b1;
    send_ar(4'd11, 32'h300, 8'd1, 3'd2, 2'b01, 20, w);
    chk("ar_refill_wait", 64'(w), 64'd3);
    wait_idle(60);

    // Error bursts.
    send_ar(4'd12, 32'h40,    8'd1, 3'd3, 2'b01, 10, w);
    send_ar(4'd13, 32'h10000, 8'd0, 3'd2, 2'b01, 10, w);
    send_ar(4'd14, 32'h50,    8'd2, 3'd2, 2'b10, 10, w);
    send_ar(4'd15, 32'h60,    8'd1, 3'd1, 2'b11, 10, w);
    wait_idle(40);

    // Randomized traffic with random rready.
    rr_rand = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      logic [7:0]  l;
      case ($urandom % 4)
        0:       a = $urandom;
        1:       a = 32'hFFFF_FFF0 + ($urandom % 16);
        default: a = $urandom & 32'h0000_FFFF;
      endcase
      l = (($urandom % 5) == 0) ? 8'd15 : 8'($urandom_range(0, 7));
      step($urandom_range(0, 2));
      send_ar(4'($urandom), a, l, 3'($urandom % 4), 2'($urandom % 4), 400, w);
    end
    rr_rand = 1'b0;
    step(1);
    rready = 1'b1;
    wait_idle(400);

    // Reset in the middle of a 4-beat burst (while beat 2 is presented).
    send_ar(4'd9, 32'h400, 8'd3, 3'd2, 2'b01, 4, w);
    step(2);
    chk("mid_beat2_data", 64'(rdata), 64'h404);
    mon_en = 1'b0;
    rst = 1'b1;
    step(1);
    chk("midrst_rvalid",  64'(rvalid),  64'd0);
    chk("midrst_arready", 64'(arready), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    step(1);
    chk("postrst_arready", 64'(arready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("postrst_no_stale", 64'(rvalid), 64'd0);
      step(1);
    end
    mon_en = 1'b1;
    send_ar(4'd4, 32'h500, 8'd1, 3'd2, 2'b01, 4, w);
    wait_idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
